// File: rtl/id_ex_latch.sv
// ID/EX pipeline register for the five-stage MIPS datapath.
// Latches the EX/M/WB control bundles and the decode-stage operands on every
// rising edge. It also detects load-use hazards against the instruction now
// in EX, raises a combinational stall to the PC and IF/ID, and turns the
// offending slot into a one-cycle bubble. A branch flush from MEM zeroes the
// control bundles of the instruction entering EX.
module id_ex_latch #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    ctl_wb_in,
  input  logic [2:0]    ctl_m_in,
  input  logic [3:0]    ctl_ex_in,
  input  logic [DW-1:0] npc_in,
  input  logic [DW-1:0] rdata1_in,
  input  logic [DW-1:0] rdata2_in,
  input  logic [DW-1:0] imm_in,
  input  logic [RW-1:0] rs_in,
  input  logic [RW-1:0] rt_in,
  input  logic [RW-1:0] rd_in,
  output logic [1:0]    ctl_wb_out,
  output logic [2:0]    ctl_m_out,
  output logic [3:0]    ctl_ex_out,
  output logic [DW-1:0] npc_out,
  output logic [DW-1:0] rdata1_out,
  output logic [DW-1:0] rdata2_out,
  output logic [DW-1:0] imm_out,
  output logic [RW-1:0] rt_out,
  output logic [RW-1:0] rd_out,
  output logic          stall
);

  // Bit 1 of the M bundle is MemRead: a load currently sitting in EX.
  localparam int M_MEMREAD = 1;

  logic hazard;
  logic rt_nonzero;
  logic rs_match;
  logic rt_match;
  logic squash;

  // Load-use detect against the load now in EX. $zero has no producer, so
  // rt_out == 0 never stalls. rt_in is compared even for I-type consumers;
  // the occasional spurious bubble is cheaper than decoding the format here.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    rt_nonzero = 1'b0;
    rs_match   = 1'b0;
    rt_match   = 1'b0;
    hazard     = 1'b0;
    rt_nonzero = (rt_out != '0);
    rs_match   = (rt_out == rs_in);
    rt_match   = (rt_out == rt_in);
    hazard     = ctl_m_out[M_MEMREAD] & rt_nonzero & (rs_match | rt_match);
  end

  // A flush already kills the consumer, so it must not also freeze the front
  // end; the upstream stages then load the branch target normally.
  assign stall  = hazard & ~flush;

  // Either a flush or a bubble clears the control bundles. Because a bubble
  // clears MemRead, the hazard self-clears after exactly one inserted slot.
  assign squash = flush | hazard;

  // Control bundles: reset and squash both zero them; otherwise latched as
  // received, including any don't-care bits the decoder leaves undefined.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      ctl_wb_out <= '0;
      ctl_m_out  <= '0;
      ctl_ex_out <= '0;
    end else if (squash) begin
      ctl_wb_out <= '0;
      ctl_m_out  <= '0;
      ctl_ex_out <= '0;
    end else begin
      ctl_wb_out <= ctl_wb_in;
      ctl_m_out  <= ctl_m_in;
      ctl_ex_out <= ctl_ex_in;
    end
  end

  // Data and register fields: cleared by reset, otherwise captured every
  // edge. Under a bubble or flush they are dead downstream because the
  // zeroed control disables every write and the branch.
  always_ff @(posedge clk) begin
    // NOTE: the datapath fields are reset too, even though zeroed control
    // makes them harmless; rt_out feeds the hazard compare and must never
    // start out undefined.
    if (rst) begin
      npc_out    <= '0;
      rdata1_out <= '0;
      rdata2_out <= '0;
      imm_out    <= '0;
      rt_out     <= '0;
      rd_out     <= '0;
    end else begin
      npc_out    <= npc_in;
      rdata1_out <= rdata1_in;
      rdata2_out <= rdata2_in;
      imm_out    <= imm_in;
      rt_out     <= rt_in;
      rd_out     <= rd_in;
    end
  end

endmodule

// File: tb/tb_id_ex_latch.sv
// Self-checking bench for id_ex_latch: a driver issues one instruction slot
// per cycle and pushes the expected stall and latched outputs into a
// scoreboard; an independent monitor pops and compares every cycle.
module tb_id_ex_latch;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic        chk_stall;
    logic        stall;
    instr_t      q;
    logic [8:0]  ctl_mask;
    string       tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [1:0]    ctl_wb_in = '0;
  logic [2:0]    ctl_m_in = '0;
  logic [3:0]    ctl_ex_in = '0;
  logic [DW-1:0] npc_in = '0, rdata1_in = '0, rdata2_in = '0, imm_in = '0;
  logic [RW-1:0] rs_in = '0, rt_in = '0, rd_in = '0;
  logic [1:0]    ctl_wb_out;
  logic [2:0]    ctl_m_out;
  logic [3:0]    ctl_ex_out;
  logic [DW-1:0] npc_out, rdata1_out, rdata2_out, imm_out;
  logic [RW-1:0] rt_out, rd_out;
  logic          stall;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t   sb[$];
  instr_t model;          // what the EX stage holds after the last edge
  logic   model_valid = 1'b0;
  logic   last_stall = 1'b0;

  always #5 clk = ~clk;

  id_ex_latch #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ctl_wb_in(ctl_wb_in), .ctl_m_in(ctl_m_in), .ctl_ex_in(ctl_ex_in),
    .npc_in(npc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in),
    .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .ctl_wb_out(ctl_wb_out), .ctl_m_out(ctl_m_out), .ctl_ex_out(ctl_ex_out),
    .npc_out(npc_out), .rdata1_out(rdata1_out), .rdata2_out(rdata2_out),
    .imm_out(imm_out), .rt_out(rt_out), .rd_out(rd_out), .stall(stall)
  );

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one slot: drive inputs after the falling edge, predict the stall
  // for this cycle and the register contents after the next rising edge.
  task automatic issue(input instr_t in, input logic fl, input logic r,
                       input logic [8:0] mask, input string tag);
    exp_t   e;
    logic   load_in_ex, uses_load;
    instr_t nxt;
    @(negedge clk);
    rst = r; flush = fl;
    ctl_wb_in = in.wb; ctl_m_in = in.m; ctl_ex_in = in.ex;
    npc_in = in.npc; rdata1_in = in.r1; rdata2_in = in.r2; imm_in = in.imm;
    rs_in = in.rs; rt_in = in.rt; rd_in = in.rd;
    // A load in EX whose nonzero destination is a source of the new slot.
    load_in_ex = (model.m == 3'b010 || model.m[1] == 1'b1);
    uses_load  = (model.rt != 0) && (model.rt == in.rs || model.rt == in.rt);
    e.chk_stall = model_valid;
    e.stall     = load_in_ex && uses_load && !fl;
    e.ctl_mask  = mask;
    e.tag       = tag;
    if (r) begin
      nxt = '0;
    end else begin
      nxt = in;
      nxt.rs = '0;
      if (fl || (load_in_ex && uses_load)) begin
        nxt.wb = '0; nxt.m = '0; nxt.ex = '0;
      end
    end
    e.q = nxt;
    sb.push_back(e);
    model = nxt;
    if (r) model_valid = 1'b1;
    last_stall = e.stall;
  endtask

  function automatic instr_t mk(input logic [1:0] wb, input logic [2:0] m,
                                input logic [3:0] ex, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd);
    instr_t i;
    i.wb = wb; i.m = m; i.ex = ex; i.rs = rs; i.rt = rt; i.rd = rd;
    i.npc = $urandom; i.r1 = $urandom; i.r2 = $urandom; i.imm = $urandom;
    return i;
  endfunction

  function automatic instr_t rnd();
    instr_t i;
    logic [2:0] m;
    m = 3'($urandom);
    if ($urandom_range(0, 1) == 0) m = 3'b010;
    i = mk(2'($urandom), m, 4'($urandom), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    return i;
  endfunction

  // Monitor: stall just before the edge, latched outputs just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() == 0) continue;
      e = sb[0];
      if (e.chk_stall) check({e.tag, ".stall"}, 128'(stall), 128'(e.stall));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".ctl"},
            128'({ctl_wb_out, ctl_m_out, ctl_ex_out} & e.ctl_mask),
            128'({e.q.wb, e.q.m, e.q.ex} & e.ctl_mask));
      check({e.tag, ".data"},
            {npc_out, rdata1_out, rdata2_out, imm_out},
            {e.q.npc, e.q.r1, e.q.r2, e.q.imm});
      check({e.tag, ".regs"}, 128'({rt_out, rd_out}), 128'({e.q.rt, e.q.rd}));
    end
  end

  initial begin
    instr_t cur;
    instr_t sw;
    int     wait_cyc;
    model = '0;

    // Reset held two cycles with nonzero inputs, then an R-type.
    issue(mk(2'b11, 3'b111, 4'b1111, 5'd9, 5'd9, 5'd9), 1'b0, 1'b1, '1, "rst0");
    issue(mk(2'b11, 3'b010, 4'b1111, 5'd7, 5'd7, 5'd7), 1'b1, 1'b1, '1, "rst1");
    issue(mk(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd8), 1'b0, 1'b0, '1, "rtype");

    // Load-use: lw rt=9 then add rs=9 -> stall, bubble, then add latched.
    issue(mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd9, 5'd0), 1'b0, 1'b0, '1, "lu_lw");
    cur = mk(2'b10, 3'b000, 4'b1100, 5'd9, 5'd4, 5'd10);
    issue(cur, 1'b0, 1'b0, '1, "lu_bubble");
    issue(cur, 1'b0, 1'b0, '1, "lu_add");

    // lw into $zero followed by a reader of $zero: no stall.
    issue(mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, '1, "z_lw");
    issue(mk(2'b10, 3'b000, 4'b1100, 5'd0, 5'd0, 5'd11), 1'b0, 1'b0, '1, "z_add");

    // Unrelated registers: no stall.
    issue(mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd9, 5'd0), 1'b0, 1'b0, '1, "u_lw");
    issue(mk(2'b10, 3'b000, 4'b1100, 5'd3, 5'd4, 5'd12), 1'b0, 1'b0, '1, "u_add");

    // Flush coinciding with a hazard: no stall, zeroed control latched.
    issue(mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd9, 5'd0), 1'b0, 1'b0, '1, "f_lw");
    issue(mk(2'b10, 3'b000, 4'b1100, 5'd9, 5'd4, 5'd13), 1'b1, 1'b0, '1, "f_add");

    // Reset arriving in the middle of a stall.
    issue(mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd6, 5'd0), 1'b0, 1'b0, '1, "rs_lw");
    cur = mk(2'b10, 3'b000, 4'b1100, 5'd2, 5'd6, 5'd14);
    issue(cur, 1'b0, 1'b1, '1, "rs_rst");
    issue(cur, 1'b0, 1'b0, '1, "rs_add");

    // SW passthrough with don't-care ex[3] and wb[0].
    sw = mk({1'b0, 1'($urandom)}, 3'b001, {1'($urandom), 3'b001},
            5'd5, 5'd6, 5'd0);
    issue(sw, 1'b0, 1'b0, 9'b10_111_0111, "sw");

    // Randomized traffic obeying the upstream hold contract on stall.
    cur = rnd();
    for (int i = 0; i < 400; i++) begin
      issue(cur, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0),
            '1, "rand");
      if (!last_stall) cur = rnd();
    end

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
